// File: rtl/regfile_sb_if.sv
// Bundles the regfile_sb writeback, issue and read-port signals.
// master drives writes, allocations and read addresses; slave is the register file.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2
);
  logic                isWreg;
  logic [AW-1:0]       Wadd;
  logic [XLEN-1:0]     Wdata;
  logic                alloc_en;
  logic [AW-1:0]       alloc_rd;
  logic [NRD*AW-1:0]   Radd;
  logic [NRD-1:0]      Ren;
  logic [NRD*XLEN-1:0] Rdata;
  logic [NRD-1:0]      Rbusy;
  logic                stall;
  logic [AW:0]         busy_cnt;

  modport master (
    output isWreg, Wadd, Wdata, alloc_en, alloc_rd, Radd, Ren,
    input  Rdata, Rbusy, stall, busy_cnt
  );

  modport slave (
    input  isWreg, Wadd, Wdata, alloc_en, alloc_rd, Radd, Ren,
    output Rdata, Rbusy, stall, busy_cnt
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file with NRD combinational read ports, one write port and a pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int NRD   = 2
) (
  input  logic         clk,
  input  logic         rstn,
  regfile_sb_if.slave  bus
);

  logic [XLEN-1:0]     regs_r [NREGS];
  logic [NREGS-1:0]    busy_r;
  logic [NREGS-1:0]    busy_nxt_s;
  logic [AW:0]         busy_cnt_r;
  logic [AW:0]         cnt_nxt_s;
  logic                wr_ok_s;
  logic                al_ok_s;
  logic [NRD*XLEN-1:0] rdata_s;
  logic [NRD-1:0]      rbusy_s;
  logic [NRD-1:0]      byp_hit_s;

  // Address 0 is the hardwired zero register; anything at or above NREGS does not exist.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != {AW{1'b0}}) && ({1'b0, a} < (AW+1)'(NREGS));
  endfunction

  assign wr_ok_s = bus.isWreg   && addr_ok(bus.Wadd);
  assign al_ok_s = bus.alloc_en && addr_ok(bus.alloc_rd);

  // Next busy vector: a new producer wins over a writeback to the same register.
  always_comb begin
    busy_nxt_s = {NREGS{1'b0}};
    cnt_nxt_s  = {(AW+1){1'b0}};
    for (int r = 0; r < NREGS; r++) begin
      busy_nxt_s[r] = (al_ok_s && (bus.alloc_rd == AW'(r))) ? 1'b1 :
                      (wr_ok_s && (bus.Wadd == AW'(r)))     ? 1'b0 : busy_r[r];
      cnt_nxt_s     = cnt_nxt_s + {{AW{1'b0}}, busy_nxt_s[r]};
    end
  end

  // Register array, busy bits and outstanding count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_r[r] <= {XLEN{1'b0}};
      end
      busy_r     <= {NREGS{1'b0}};
      busy_cnt_r <= {(AW+1){1'b0}};
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (wr_ok_s && (bus.Wadd == AW'(r))) begin
          regs_r[r] <= bus.Wdata;
        end
      end
      busy_r     <= busy_nxt_s;
      busy_cnt_r <= cnt_nxt_s;
    end
  end

  // Forwarding match per port; held low in reset so outputs read zero immediately.
  always_comb begin
    byp_hit_s = {NRD{1'b0}};
    for (int i = 0; i < NRD; i++) begin
`ifdef REGFILE_BYPASS_EN
      byp_hit_s[i] = rstn && wr_ok_s && (bus.Radd[i*AW +: AW] == bus.Wadd);
`else
      byp_hit_s[i] = 1'b0;
`endif
    end
  end

  // Read mux: loop starts at 1 so address 0 and out-of-range addresses return zero, never busy.
  always_comb begin
    rdata_s = {(NRD*XLEN){1'b0}};
    rbusy_s = {NRD{1'b0}};
    for (int i = 0; i < NRD; i++) begin
      for (int r = 1; r < NREGS; r++) begin
        rdata_s[i*XLEN +: XLEN] = (bus.Radd[i*AW +: AW] == AW'(r)) ? regs_r[r] : rdata_s[i*XLEN +: XLEN];
        rbusy_s[i]              = (bus.Radd[i*AW +: AW] == AW'(r)) ? busy_r[r] : rbusy_s[i];
      end
      rdata_s[i*XLEN +: XLEN] = byp_hit_s[i] ? bus.Wdata : rdata_s[i*XLEN +: XLEN];
      rbusy_s[i]              = byp_hit_s[i] ? (al_ok_s && (bus.alloc_rd == bus.Wadd)) : rbusy_s[i];
    end
  end

  assign bus.Rdata    = rdata_s;
  assign bus.Rbusy    = rbusy_s;
  assign bus.stall    = |(bus.Ren & rbusy_s);
  assign bus.busy_cnt = busy_cnt_r;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the read ports and counters.
module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  b;
    logic        st;
    logic [5:0]  cnt;
  } exp_t;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  regfile_sb_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD)) bus ();

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW), .NRD(NRD)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input string fld, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%h required=%h", name, fld, act, req);
    end
  endtask

  // Monitor: every queued expectation is compared at the next falling edge.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp(e.name, "rdata0", bus.Rdata[31:0], e.d0);
      cmp(e.name, "rdata1", bus.Rdata[63:32], e.d1);
      cmp(e.name, "rbusy", {30'd0, bus.Rbusy}, {30'd0, e.b});
      cmp(e.name, "stall", {31'd0, bus.stall}, {31'd0, e.st});
      cmp(e.name, "busy_cnt", {26'd0, bus.busy_cnt}, {26'd0, e.cnt});
    end
  end

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic ae, input logic [4:0] ar,
                       input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] ren);
    bus.isWreg   = we;
    bus.Wadd     = wa;
    bus.Wdata    = wd;
    bus.alloc_en = ae;
    bus.alloc_rd = ar;
    bus.Radd     = {r1, r0};
    bus.Ren      = ren;
  endtask

  task automatic expect_out(input string name, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [1:0] b, input logic st, input logic [5:0] cnt);
    exp_t e;
    e.name = name; e.d0 = d0; e.d1 = d1; e.b = b; e.st = st; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rstn     = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd1, 5'd31, 2'b11);
    #100;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    expect_out("reset", 32'd0, 32'd0, 2'b00, 1'b0, 6'd0);
    tick();

    // x0 is hardwired: write and alloc to address 0 are dropped
    drive(1'b1, 5'd0, 32'h1, 1'b1, 5'd0, 5'd0, 5'd0, 2'b11);
    expect_out("x0_pre", 32'd0, 32'd0, 2'b00, 1'b0, 6'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 2'b11);
    expect_out("x0", 32'd0, 32'd0, 2'b00, 1'b0, 6'd0);
    tick();

    // consecutive writes, then read port0=reg1 port1=reg2
    drive(1'b1, 5'd1, 32'h2, 1'b0, 5'd0, 5'd1, 5'd2, 2'b11);
    tick();
    drive(1'b1, 5'd2, 32'h3, 1'b0, 5'd0, 5'd1, 5'd2, 2'b11);
    expect_out("wr_mid", 32'h2, BYP ? 32'h3 : 32'h0, 2'b00, 1'b0, 6'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd1, 5'd2, 2'b11);
    expect_out("wr_rd", 32'h2, 32'h3, 2'b00, 1'b0, 6'd0);
    tick();

    // scoreboard: alloc reg5, then writeback
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd5, 5'd1, 2'b01);
    expect_out("alloc_pre", 32'd0, 32'h2, 2'b00, 1'b0, 6'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd1, 2'b01);
    expect_out("alloc5", 32'd0, 32'h2, 2'b01, 1'b1, 6'd1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd1, 2'b00);
    expect_out("busy_noren", 32'd0, 32'h2, 2'b01, 1'b0, 6'd1);
    tick();
    drive(1'b1, 5'd5, 32'hDEAD, 1'b0, 5'd0, 5'd5, 5'd1, 2'b01);
    expect_out("wb5_same", BYP ? 32'hDEAD : 32'd0, 32'h2, BYP ? 2'b00 : 2'b01, BYP ? 1'b0 : 1'b1, 6'd1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd1, 2'b01);
    expect_out("wb5", 32'hDEAD, 32'h2, 2'b00, 1'b0, 6'd0);
    tick();

    // collision: write and alloc reg7 on the same edge
    drive(1'b1, 5'd7, 32'h55, 1'b1, 5'd7, 5'd7, 5'd5, 2'b11);
    expect_out("coll_same", BYP ? 32'h55 : 32'd0, 32'hDEAD, BYP ? 2'b01 : 2'b00, BYP, 6'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd5, 2'b11);
    expect_out("coll", 32'h55, 32'hDEAD, 2'b01, 1'b1, 6'd1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd5, 2'b11);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd5, 2'b11);
    expect_out("realloc", 32'h55, 32'hDEAD, 2'b01, 1'b1, 6'd1);
    tick();

    // write reg7 and alloc reg9 on the same edge
    drive(1'b1, 5'd7, 32'h77, 1'b1, 5'd9, 5'd7, 5'd9, 2'b11);
    expect_out("diff_same", BYP ? 32'h77 : 32'h55, 32'd0, BYP ? 2'b00 : 2'b01, ~BYP, 6'd1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd9, 2'b11);
    expect_out("diff", 32'h77, 32'd0, 2'b10, 1'b1, 6'd1);
    tick();

    // write reg3 while reading it
    drive(1'b1, 5'd3, 32'hA5, 1'b0, 5'd0, 5'd3, 5'd9, 2'b01);
    expect_out("byp3_same", BYP ? 32'hA5 : 32'd0, 32'd0, 2'b10, 1'b0, 6'd1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd9, 2'b01);
    expect_out("byp3", 32'hA5, 32'd0, 2'b10, 1'b0, 6'd1);
    tick();

    // asynchronous reset dropped between edges with a write and alloc in flight
    drive(1'b1, 5'd4, 32'h99, 1'b1, 5'd4, 5'd7, 5'd4, 2'b11);
    #2;
    rstn = 1'b0;
    expect_out("mid_rst", 32'd0, 32'd0, 2'b00, 1'b0, 6'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd7, 2'b11);
    rstn = 1'b1;
    expect_out("post_rst", 32'd0, 32'd0, 2'b00, 1'b0, 6'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd9, 2'b11);
    expect_out("post_rst2", 32'd0, 32'd0, 2'b00, 1'b0, 6'd0);
    tick();

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-cycle register file, for the pipelined RV32I core.
- Provides a generic register array with NRD combinational read ports and one synchronous write port. Register 0 is hardwired to zero.
- Adds a pending-write scoreboard: busy bit per register, set at issue, cleared at writeback. Drives a per-port busy flag, a decode stall and an outstanding-write count.

Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (2..2^AW)
- AW, 5, register address width
- NRD, 2, number of read ports (1..4)

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- isWreg  in  1  writeback enable
- Wadd  in  AW  writeback register address
- Wdata  in  XLEN  writeback data
- alloc_en  in  1  issue: mark alloc_rd as pending
- alloc_rd  in  AW  destination register being issued
- Radd  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW]
- Ren  in  NRD  read-port valid (qualifies stall only)
- Rdata  out  NRD*XLEN  read data; port i uses bits [i*XLEN +: XLEN]
- Rbusy  out  NRD  port i source has a pending write
- stall  out  1  OR over i of (Ren[i] & Rbusy[i])
- busy_cnt  out  AW+1  number of registers currently pending

Behaviour:
- Clock and reset: one clock (clk); reset asynchronous, active-low (rstn).
- Reset (rstn=0, asynchronous):
  - all registers = 0, all busy bits = 0, busy_cnt = 0;
  - Rdata = 0 and Rbusy = 0 for all ports, stall = 0.
  - Reset is honoured mid-operation: any in-flight write or alloc is lost.
- Write: at posedge, if isWreg && Wadd!=0 && Wadd<NREGS then reg[Wadd] <= Wdata and busy[Wadd] <= 0. One-cycle write latency.
- Alloc: at posedge, if alloc_en && alloc_rd!=0 && alloc_rd<NREGS then busy[alloc_rd] <= 1.
- Simultaneous write and alloc:
  - Same address: data is written and busy ends 1 (the new producer wins).
  - Different addresses: both take effect.
- Alloc of an already-busy register: busy stays 1 and busy_cnt is unchanged (no double count).
- Write to a non-busy register: legal; data is written and busy stays 0.
- Read (combinational, zero latency):
  - Rdata[i] = reg[Radd[i]].
  - Rdata[i] = 0 when Radd[i]==0 or Radd[i]>=NREGS.
  - Rbusy[i] = busy[Radd[i]], using registered busy state only; 0 for address 0 or out of range.
- Address 0 and out-of-range addresses: writes and allocs are ignored, reads return 0, never busy.
- busy_cnt: registered popcount of the busy vector; updates the cycle after the causing edge. Maximum NREGS-1.
- Without bypass, a read of the register being written in the same cycle returns the old value with Rbusy still 1.
- No X propagation: every output is defined when Ren=0.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. When isWreg && Wadd==Radd[i] && Wadd!=0 && Wadd<NREGS:
  - Rdata[i] = Wdata in the same cycle;
  - Rbusy[i] = 0, unless alloc_en && alloc_rd==Wadd in that cycle, in which case Rbusy[i] = 1.
- Not defined: reads reflect only the stored array, as described in Behaviour; no forwarding logic is synthesised.

Test Plan:
- Reset/zero: hold rstn=0 for 100 ns, then release; read ports 0/1 at addrs 1 and 31 -> Rdata=0, Rbusy=0, stall=0, busy_cnt=0.
- x0 hardwired: isWreg=1, Wadd=0, Wdata=32'h1 for one edge; alloc_rd=0 -> reading addr 0 gives Rdata=0, Rbusy=0, busy_cnt=0.
- Write/read: write reg1=32'h2 and reg2=32'h3 on consecutive edges; then Radd={2,1} -> Rdata port0=2, port1=3 with no stall.
- Scoreboard:
  - alloc reg5; Ren=2'b01, Radd0=5 -> Rbusy[0]=1, stall=1, busy_cnt=1;
  - writeback reg5=32'hDEAD -> next cycle Rbusy=0, stall=0, Rdata=32'hDEAD, busy_cnt=0.
- Collision: same edge isWreg to reg7=32'h55 and alloc reg7 -> reg7=32'h55, busy[7]=1, busy_cnt=1. Re-alloc reg7 -> busy_cnt stays 1.
- Bypass/mid-op reset:
  - With REGFILE_BYPASS_EN, write reg3=32'hA5 while reading reg3 -> Rdata=32'hA5 in that cycle. Without the macro -> old value until the next cycle.
  - Drop rstn asynchronously between edges -> all outputs read 0 immediately.
